// File: rtl/exec_sequencer_pkg.sv
// Shared opcode/funct constants, ALU command codes and sequencer states.
package exec_sequencer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_ADDI = 2'b10,
    ALU_NOP  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK
  } state_e;

endpackage

// File: rtl/exec_sequencer_instr_decode.sv
// Combinational instruction decoder: maps IR fields to ALU op, destination and legality.
// Only the fields that matter are passed in, so the unused shamt bits never reach this block.
module instr_decode
  import exec_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic [4:0] dest,
  output logic       legal
);

  // Decode ADD/SUB (R-type, dest rd) and ADDI (dest rt); everything else is illegal.
  always_comb begin
    alu_op = ALU_NOP;
    dest   = '0;
    legal  = 1'b0;
    if (opcode == OP_RTYPE) begin
      if (funct == FN_ADD) begin
        alu_op = ALU_ADD;
        dest   = rd;
        legal  = 1'b1;
      end else if (funct == FN_SUB) begin
        alu_op = ALU_SUB;
        dest   = rd;
        legal  = 1'b1;
      end
    end else if (opcode == OP_ADDI) begin
      alu_op = ALU_ADDI;
      dest   = rt;
      legal  = 1'b1;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Four-state fetch/decode/execute/writeback sequencer driving the 2-bit-opcode ALU.
module exec_sequencer
  import exec_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [15:0] alu_imm,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic [31:0] retired
);

  state_e      state, state_next;
  logic [31:0] ir_q, a_q, b_q, res_q, pc_q, retired_q;
  logic [4:0]  dest_q;
  alu_op_e     op_q;
  logic        illegal_q;

  alu_op_e     dec_op;
  logic [4:0]  dec_dest;
  logic        dec_legal;

  instr_decode u_decode (
    .opcode (ir_q[31:26]),
    .rt     (ir_q[20:16]),
    .rd     (ir_q[15:11]),
    .funct  (ir_q[5:0]),
    .alu_op (dec_op),
    .dest   (dec_dest),
    .legal  (dec_legal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_next = state;
    instr_req  = 1'b0;
    alu_op     = ALU_NOP;
    wb_en      = 1'b0;
    case (state)
      FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) state_next = DECODE;
      end
      DECODE:    state_next = dec_legal ? EXECUTE : FETCH;
      EXECUTE: begin
        alu_op     = op_q;
        state_next = WRITEBACK;
      end
      WRITEBACK: begin
        wb_en      = (dest_q != '0);
        state_next = FETCH;
      end
      default:   state_next = FETCH;
    endcase
  end

  // Datapath registers: IR/pc on fetch, operands on decode, result on execute, count on writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      dest_q    <= '0;
      op_q      <= ALU_NOP;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            ir_q <= instr;
            pc_q <= pc_q + 32'd4;
          end
        end
        DECODE: begin
          a_q       <= rs_data;
          b_q       <= rt_data;
          op_q      <= dec_op;
          dest_q    <= dec_dest;
          illegal_q <= ~dec_legal;
        end
        EXECUTE:   res_q     <= alu_result;
        WRITEBACK: retired_q <= retired_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign pc      = pc_q;
  assign rs_addr = ir_q[25:21];
  assign rt_addr = ir_q[20:16];
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_imm = ir_q[15:0];
  assign wb_addr = dest_q;
  assign wb_data = res_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer with a tiny register file and ALU model.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_a, alu_b;
  logic [15:0] alu_imm;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [31:0] retired;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_retired;

  exec_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_imm     (alu_imm),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Fixed register file: r1=5, r2=7, everything else 0.
  function automatic logic [31:0] regval(input logic [4:0] a);
    case (a)
      5'd1:    return 32'd5;
      5'd2:    return 32'd7;
      default: return 32'd0;
    endcase
  endfunction

  assign rs_data = regval(rs_addr);
  assign rt_data = regval(rt_addr);

  // Reference ALU: add, sub, add zero-extended immediate.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a + {16'h0000, alu_imm};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from a FETCH cycle through to the next FETCH cycle.
  task automatic exec_instr(input logic [31:0] w, input logic [1:0] exp_op,
                            input logic exp_wb, input logic [4:0] exp_addr,
                            input logic [31:0] exp_data, input logic is_illegal,
                            input logic noise);
    check("fetch_req", {31'd0, instr_req}, 32'd1);
    check("fetch_pc", pc, exp_pc);
    instr       = w;
    instr_valid = 1'b1;
    step();
    exp_pc = exp_pc + 32'd4;
    if (noise) instr = 32'hFC000000;
    else       instr_valid = 1'b0;
    // DECODE
    check("dec_req", {31'd0, instr_req}, 32'd0);
    check("dec_pc", pc, exp_pc);
    check("dec_op", {30'd0, alu_op}, 32'd3);
    step();
    if (is_illegal) begin
      instr_valid = 1'b0;
      check("ill_pulse", {31'd0, illegal}, 32'd1);
      check("ill_req", {31'd0, instr_req}, 32'd1);
      check("ill_op", {30'd0, alu_op}, 32'd3);
      check("ill_wb", {31'd0, wb_en}, 32'd0);
      step();
      check("ill_clear", {31'd0, illegal}, 32'd0);
      check("ill_wb2", {31'd0, wb_en}, 32'd0);
      check("ill_retired", retired, exp_retired);
      check("ill_pc", pc, exp_pc);
    end else begin
      // EXECUTE
      check("ex_op", {30'd0, alu_op}, {30'd0, exp_op});
      check("ex_a", alu_a, regval(w[25:21]));
      check("ex_b", alu_b, regval(w[20:16]));
      check("ex_imm", {16'd0, alu_imm}, {16'd0, w[15:0]});
      check("ex_req", {31'd0, instr_req}, 32'd0);
      check("ex_illegal", {31'd0, illegal}, 32'd0);
      step();
      // WRITEBACK
      check("wb_en", {31'd0, wb_en}, {31'd0, exp_wb});
      if (exp_wb) begin
        check("wb_addr", {27'd0, wb_addr}, {27'd0, exp_addr});
        check("wb_data", wb_data, exp_data);
      end
      check("wb_op", {30'd0, alu_op}, 32'd3);
      check("wb_pc", pc, exp_pc);
      instr_valid = 1'b0;
      step();
      exp_retired = exp_retired + 32'd1;
      check("retired", retired, exp_retired);
      check("next_req", {31'd0, instr_req}, 32'd1);
      check("next_wb", {31'd0, wb_en}, 32'd0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    exp_pc      = '0;
    exp_retired = '0;
    step();
    step();
    check("rst_req", {31'd0, instr_req}, 32'd1);
    check("rst_op", {30'd0, alu_op}, 32'd3);
    check("rst_wb", {31'd0, wb_en}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_imm", {16'd0, alu_imm}, 32'd0);
    check("rst_wbaddr", {27'd0, wb_addr}, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    reset = 1'b0;

    // ADD r3 = r1 + r2
    exec_instr(32'h00221820, 2'b00, 1'b1, 5'd3, 32'd12, 1'b0, 1'b0);
    check("add_pc", pc, 32'd4);
    // SUB r4 = r1 - r2, with instr_valid held high while not requesting
    exec_instr(32'h00222022, 2'b01, 1'b1, 5'd4, 32'hFFFFFFFE, 1'b0, 1'b1);
    // ADDI r5 = r1 + 0x8000
    exec_instr(32'h20258000, 2'b10, 1'b1, 5'd5, 32'h00008005, 1'b0, 1'b0);
    check("addi_pc", pc, 32'd12);
    // Illegal opcode
    exec_instr(32'hFC000000, 2'b11, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    // Illegal R-type funct
    exec_instr(32'h00221821, 2'b11, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

    // Fetch stall for three cycles
    for (int i = 0; i < 3; i++) begin
      check("stall_req", {31'd0, instr_req}, 32'd1);
      check("stall_pc", pc, exp_pc);
      check("stall_op", {30'd0, alu_op}, 32'd3);
      check("stall_wb", {31'd0, wb_en}, 32'd0);
      step();
    end
    exec_instr(32'h00221820, 2'b00, 1'b1, 5'd3, 32'd12, 1'b0, 1'b0);

    // rd = 0: no write strobe but still retires
    exec_instr(32'h00220020, 2'b00, 1'b0, 5'd0, 32'd12, 1'b0, 1'b0);

    // Reset in the middle of an instruction (during EXECUTE)
    check("pre_rst_pc", pc, exp_pc);
    instr       = 32'h00221820;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    check("mid_ex_op", {30'd0, alu_op}, 32'd0);
    reset = 1'b1;
    step();
    check("mid_rst_wb", {31'd0, wb_en}, 32'd0);
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_retired", retired, 32'd0);
    check("mid_rst_req", {31'd0, instr_req}, 32'd1);
    check("mid_rst_op", {30'd0, alu_op}, 32'd3);
    reset = 1'b0;
    step();
    check("post_rst_req", {31'd0, instr_req}, 32'd1);
    check("post_rst_pc", pc, 32'd0);
    check("post_rst_retired", retired, 32'd0);
    check("post_rst_wb", {31'd0, wb_en}, 32'd0);
    exp_pc      = '0;
    exp_retired = '0;
    exec_instr(32'h00221820, 2'b00, 1'b1, 5'd3, 32'd12, 1'b0, 1'b0);
    check("final_pc", pc, 32'd4);
    check("final_retired", retired, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
